// File: rtl/ufm_read_arbiter.sv
// Round-robin arbiter sharing the UFM page buffer's random-read port among N_REQ requesters,
// with flush sequencing, a mandatory gap cycle after every operation, and a read timeout.
//
// state | meaning
// IDLE  | serve a pending flush first, otherwise grant the next requester round-robin
// READ  | buf_read_en/buf_addr held until buf_rand_valid or the cycle budget runs out
// GAP   | one dead cycle; a stale buf_rand_valid echo from the buffer is ignored here
module ufm_read_arbiter #(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 15,
  parameter int TIMEOUT = 4095
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ack,
  output logic [N_REQ-1:0]        req_err,
  output logic [7:0]              req_data,
  input  logic                    flush_req,
  output logic                    flush_ack,
  output logic [ADDR_W-1:0]       buf_addr,
  output logic                    buf_read_en,
  output logic                    buf_flush,
  input  logic [7:0]              buf_data,
  input  logic                    buf_rand_valid
);

  typedef enum logic [1:0] {IDLE, READ, GAP} state_t;

  localparam logic [11:0] TO_LAST = 12'(TIMEOUT - 1);

  state_t            state;
  logic [1:0]        rr;
  logic [1:0]        grant;
  logic [11:0]       cnt;
  logic [1:0]        pick;
  logic              found;
  logic [ADDR_W-1:0] pick_addr;
  logic [1:0]        next_rr;

  assign req_data = buf_data;

  // First pending requester at or after the rr pointer, wrapping.
  always_comb begin
    pick  = rr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_valid[(int'(rr) + k) % N_REQ]) begin
        found = 1'b1;
        pick  = 2'((int'(rr) + k) % N_REQ);
      end
    end
  end

  assign pick_addr = req_addr[int'(pick)*ADDR_W +: ADDR_W];
  assign next_rr   = (int'(grant) == N_REQ - 1) ? 2'd0 : grant + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ack     <= '0;
      req_err     <= '0;
      flush_ack   <= 1'b0;
      buf_flush   <= 1'b0;
      buf_read_en <= 1'b0;
      buf_addr    <= '0;
      rr          <= '0;
      grant       <= '0;
      cnt         <= '0;
    end else begin
      req_ack   <= '0;
      req_err   <= '0;
      flush_ack <= 1'b0;
      buf_flush <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_req) begin
            flush_ack <= 1'b1;
            buf_flush <= 1'b1;
            state     <= GAP;
          end else if (found) begin
            grant       <= pick;
            buf_addr    <= pick_addr;
            buf_read_en <= 1'b1;
            cnt         <= '0;
            state       <= READ;
          end
        end
        READ: begin
          // A valid arriving on the last budget cycle still counts as a hit.
          if (buf_rand_valid) begin
            req_ack[grant] <= 1'b1;
            buf_read_en    <= 1'b0;
            rr             <= next_rr;
            state          <= GAP;
          end else if (cnt == TO_LAST) begin
            req_err[grant] <= 1'b1;
            buf_read_en    <= 1'b0;
            rr             <= next_rr;
            state          <= GAP;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
